// File: rtl/xadc_scan_sequencer.sv
// Periodic XADC DRP read sequencer: every SCAN_PERIOD cycles reads NUM_CH consecutive status
// registers into a sample bank and presents the selected channel's raw code on data_out.
module xadc_scan_sequencer #(
    parameter int unsigned NUM_CH       = 4,
    parameter logic [6:0]  CH_BASE_ADDR = 7'h10,
    parameter int unsigned SCAN_PERIOD  = 20000000,
    parameter int unsigned DRP_TIMEOUT  = 255
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [2:0]  sel,
    input  logic        drdy,
    input  logic [15:0] drp_do,
    output logic        den,
    output logic        dwe,
    output logic [6:0]  daddr,
    output logic [15:0] di,
    output logic [15:0] data_out,
    output logic        scan_done,
    output logic        busy,
    output logic [7:0]  timeout_err,
    output logic        overrun
);
    localparam int unsigned TW     = (DRP_TIMEOUT > 0) ? $clog2(DRP_TIMEOUT + 1) : 1;
    localparam logic [31:0]   PLast  = 32'(SCAN_PERIOD - 1);
    localparam logic [TW-1:0] TLast  = TW'(DRP_TIMEOUT);
    localparam logic [2:0]    LastCh = 3'(NUM_CH - 1);
    localparam logic [3:0]    NumCh  = 4'(NUM_CH);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StNext, StDone} state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [31:0]   r_pcnt;
    logic [TW-1:0] r_tcnt;
    logic [2:0]    r_ch;
    logic [6:0]    r_daddr;
    logic [15:0]   r_bank [8];
    logic [15:0]   r_data_out;
    logic [7:0]    r_timeout_err;
    logic          r_overrun;
    logic          w_tick;
    logic          w_rd_ok;
    logic          w_rd_to;

    assign w_tick  = (r_pcnt == PLast);
    // Data wins over a timeout landing in the same WAIT cycle.
    assign w_rd_ok = (r_state == StWait) && drdy;
    assign w_rd_to = (r_state == StWait) && !drdy && (r_tcnt == TLast);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_tick) w_state_nxt = StIssue;
            StIssue: w_state_nxt = StWait;
            StWait:  if (w_rd_ok || w_rd_to) w_state_nxt = StNext;
            StNext:  w_state_nxt = (r_ch == LastCh) ? StDone : StIssue;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state       <= StIdle;
            r_pcnt        <= '0;
            r_tcnt        <= '0;
            r_ch          <= '0;
            r_daddr       <= '0;
            r_data_out    <= '0;
            r_timeout_err <= '0;
            r_overrun     <= 1'b0;
            for (int i = 0; i < 8; i++) r_bank[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_tick ? '0 : r_pcnt + 32'd1;

            // A tick during a scan is dropped; the scan in flight is left alone.
            if (w_tick && (r_state != StIdle)) r_overrun <= 1'b1;

            if ((r_state == StIdle) && w_tick) begin
                r_ch    <= '0;
                r_daddr <= CH_BASE_ADDR;
            end else if ((r_state == StNext) && (r_ch != LastCh)) begin
                r_ch    <= r_ch + 3'd1;
                r_daddr <= CH_BASE_ADDR + {4'b0000, r_ch + 3'd1};
            end

            if (r_state == StIssue) begin
                r_tcnt <= '0;
            end else if ((r_state == StWait) && !drdy && (r_tcnt != TLast)) begin
                r_tcnt <= r_tcnt + TW'(1);
            end

            if (w_rd_ok) r_bank[r_ch] <= drp_do;
            if (w_rd_to) r_timeout_err[r_ch] <= 1'b1;

            r_data_out <= ({1'b0, sel} < NumCh) ? r_bank[sel] : 16'h0000;
        end
    end

    assign den         = (r_state == StIssue);
    assign dwe         = 1'b0;
    assign di          = 16'h0000;
    assign daddr       = r_daddr;
    assign data_out    = r_data_out;
    assign scan_done   = (r_state == StDone);
    assign busy        = (r_state != StIdle);
    assign timeout_err = r_timeout_err;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_xadc_scan_sequencer.sv
// Directed bench: a main instance (period 100, timeout 8) and a short-period instance whose
// DRP model answers after 30 cycles, so that its scans overrun the period.
module tb_xadc_scan_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_o;
    logic [2:0]  sel, sel_o;
    logic        drdy, drdy_o;
    logic [15:0] drp_do, drp_do_o;
    logic        den, dwe, scan_done, busy, overrun;
    logic        den_o, dwe_o, scan_done_o, busy_o, overrun_o;
    logic [6:0]  daddr, daddr_o;
    logic [15:0] di, data_out, di_o, data_out_o;
    logic [7:0]  timeout_err, timeout_err_o;

    xadc_scan_sequencer #(
        .NUM_CH(4), .CH_BASE_ADDR(7'h10), .SCAN_PERIOD(100), .DRP_TIMEOUT(8)
    ) u_dut (
        .CLK100MHZ(clk), .reset(rst), .sel(sel), .drdy(drdy), .drp_do(drp_do),
        .den(den), .dwe(dwe), .daddr(daddr), .di(di), .data_out(data_out),
        .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
    );

    xadc_scan_sequencer #(
        .NUM_CH(4), .CH_BASE_ADDR(7'h10), .SCAN_PERIOD(60), .DRP_TIMEOUT(40)
    ) u_dut_ovr (
        .CLK100MHZ(clk), .reset(rst_o), .sel(sel_o), .drdy(drdy_o), .drp_do(drp_do_o),
        .den(den_o), .dwe(dwe_o), .daddr(daddr_o), .di(di_o), .data_out(data_out_o),
        .scan_done(scan_done_o), .busy(busy_o), .timeout_err(timeout_err_o),
        .overrun(overrun_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // DRP model configuration for the main instance
    logic [15:0] base       = 16'hA5A0;
    int unsigned rsp_delay  = 0;
    logic [6:0]  skip_addr  = 7'h7f;
    bit          skip_never = 1'b1;
    int unsigned skip_delay = 0;
    bit          junk_after = 1'b0;
    bit          spur       = 1'b0;

    bit          pend, pend_o;
    int unsigned cnt, cnt_o;
    logic [15:0] rdata, rdata_o;
    bit          junk;
    logic [6:0]  addrs [8];

    initial begin
        pend = 1'b0; junk = 1'b0; cnt = 0; rdata = '0;
        drdy = 1'b0; drp_do = '0;
        forever begin
            @(posedge clk); #1;
            drdy = 1'b0; drp_do = 16'h0000;
            if (junk) begin
                drdy = 1'b1; drp_do = 16'hFFFF; junk = 1'b0;
            end else if (pend) begin
                if (cnt == 0) begin
                    drdy = 1'b1; drp_do = rdata; pend = 1'b0; junk = junk_after;
                end else begin
                    cnt--;
                end
            end
            if (spur) begin
                drdy = 1'b1; drp_do = 16'hFFFF;
            end
            if (den) begin
                if (daddr == skip_addr) begin
                    if (!skip_never) begin
                        pend = 1'b1; cnt = skip_delay; rdata = 16'hEEEE;
                    end
                end else begin
                    pend = 1'b1; cnt = rsp_delay; rdata = base + 16'(daddr - 7'h10);
                end
            end
        end
    end

    initial begin
        pend_o = 1'b0; cnt_o = 0; rdata_o = '0;
        drdy_o = 1'b0; drp_do_o = '0;
        forever begin
            @(posedge clk); #1;
            drdy_o = 1'b0;
            if (pend_o) begin
                if (cnt_o == 0) begin
                    drdy_o = 1'b1; drp_do_o = rdata_o; pend_o = 1'b0;
                end else begin
                    cnt_o--;
                end
            end
            if (den_o) begin
                pend_o = 1'b1; cnt_o = 30; rdata_o = 16'hA5A0 + 16'(daddr_o - 7'h10);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [2:0] s, input logic [15:0] exp, input string tag);
        sel = s;
        @(negedge clk);
        check(tag, 64'(data_out), 64'(exp));
    endtask

    task automatic check_reset(input string tag);
        check({tag, " ctl"}, 64'({den, dwe, scan_done, busy, overrun}), 64'd0);
        check({tag, " daddr"}, 64'(daddr), 64'd0);
        check({tag, " di"}, 64'(di), 64'd0);
        check({tag, " data_out"}, 64'(data_out), 64'd0);
        check({tag, " timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    // Waits (bounded) for the next den, then follows the scan up to scan_done.
    // k: cycles until den; c: cycles from first den to scan_done; n: den pulses seen.
    task automatic run_scan(output int k, output int c, output int n);
        k = 0; c = 0; n = 0;
        while (!den && k < 400) begin
            @(negedge clk);
            k++;
        end
        while (c < 400) begin
            if (den) begin
                if (n < 8) addrs[n] = daddr;
                n++;
            end
            if (scan_done) break;
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, c, n;
        rst = 1'b1; rst_o = 1'b1; sel = 3'd0; sel_o = 3'd3;
        repeat (3) @(negedge clk);
        check_reset("reset");
        check("ovr reset", 64'({den_o, dwe_o, scan_done_o, busy_o, overrun_o, di_o, daddr_o,
                                data_out_o, timeout_err_o}), 64'd0);

        // Overrun instance: scan of 133 cycles against a 60-cycle period
        rst_o = 1'b0;
        k = 0;
        while (!den_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("ovr first den", 64'(k), 64'd60);
        c = 0; n = 0;
        while (c < 400) begin
            if (den_o) begin
                if (n < 8) addrs[n] = daddr_o;
                n++;
            end
            if (scan_done_o) break;
            @(negedge clk);
            c++;
        end
        check("ovr scan len", 64'(c), 64'd132);
        check("ovr den count", 64'(n), 64'd4);
        check("ovr order", 64'({addrs[0], addrs[1], addrs[2], addrs[3]}),
              64'({7'h10, 7'h11, 7'h12, 7'h13}));
        check("ovr overrun", 64'(overrun_o), 64'd1);
        check("ovr timeout_err", 64'(timeout_err_o), 64'd0);
        @(negedge clk);
        check("ovr data ch3", 64'(data_out_o), 64'h0000_0000_0000_A5A3);
        rst_o = 1'b1;

        // Main instance: normal scan, immediate responses
        rst = 1'b0;
        run_scan(k, c, n);
        check("first den latency", 64'(k), 64'd100);
        check("scan len", 64'(c), 64'd12);
        check("den count", 64'(n), 64'd4);
        check("addr order", 64'({addrs[0], addrs[1], addrs[2], addrs[3]}),
              64'({7'h10, 7'h11, 7'h12, 7'h13}));
        check("no err", 64'({timeout_err, overrun}), 64'd0);
        peek(3'd2, 16'hA5A2, "sel2 A5A2");
        peek(3'd0, 16'hA5A0, "sel0 A5A0");

        // Channel 1 never answers
        base = 16'hB0B0; skip_addr = 7'h11; skip_never = 1'b1;
        run_scan(k, c, n);
        check("timeout scan len", 64'(c), 64'd20);
        check("timeout flag", 64'(timeout_err), 64'h02);
        peek(3'd1, 16'hA5A1, "ch1 kept");
        peek(3'd2, 16'hB0B2, "ch2 updated");
        peek(3'd3, 16'hB0B3, "ch3 updated");

        // drdy exactly when tcnt reaches the timeout: data must win
        skip_addr = 7'h7f; rsp_delay = 8; base = 16'hC0C0;
        run_scan(k, c, n);
        check("edge scan len", 64'(c), 64'd44);
        check("edge flags sticky", 64'(timeout_err), 64'h02);
        peek(3'd1, 16'hC0C1, "edge ch1 stored");
        peek(3'd3, 16'hC0C3, "edge ch3 stored");

        // Spurious drdy in NEXT and in IDLE
        rsp_delay = 0; junk_after = 1'b1; base = 16'hD0D0;
        run_scan(k, c, n);
        check("junk scan len", 64'(c), 64'd12);
        @(negedge clk);
        check("idle before spur", 64'(busy), 64'd0);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        peek(3'd1, 16'hD0D1, "spur ch1");
        peek(3'd3, 16'hD0D3, "spur ch3");
        peek(3'd5, 16'h0000, "sel5 zero");
        peek(3'd7, 16'h0000, "sel7 zero");

        // Reset during WAIT of channel 2, with its response arriving after reset
        junk_after = 1'b0; base = 16'hF0F0;
        skip_addr = 7'h12; skip_never = 1'b0; skip_delay = 3;
        sel = 3'd2;
        k = 0;
        while (!(den && daddr == 7'h12) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("reach ch2 issue", 64'({den, daddr}), 64'({1'b1, 7'h12}));
        @(negedge clk);
        check("busy in wait", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid-scan reset");
        skip_addr = 7'h7f;
        rst = 1'b0;
        k = 0;
        while (!den && k < 400) begin
            @(negedge clk);
            k++;
            if (k == 6) check("late drdy ignored", 64'(data_out), 64'd0);
        end
        check("restart latency", 64'(k), 64'd100);
        run_scan(k, c, n);
        check("restart scan len", 64'(c), 64'd12);
        peek(3'd2, 16'hF0F2, "restart ch2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
